// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU front end: sequencer state, redirect kinds
// and fixed PC addresses.
package cpu_pkg;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Numeric order is priority order, so a plain compare picks the winner
  typedef enum logic [1:0] {
    NONE     = 2'd0,
    BRANCH   = 2'd1,
    TRAP_RET = 2'd2,
    TRAP     = 2'd3
  } redirect_e;

  localparam logic [31:0] PC_STEP  = 32'd4;
  localparam logic [31:0] RESET_PC = 32'hFFFF_FFFC;
  localparam logic [31:0] TRAP_VEC = 32'h0000_0100;

  function automatic redirect_e req_kind(input logic trap_req, input logic ret_req,
                                         input logic branch_req);
    if (trap_req) begin
      return TRAP;
    end else if (ret_req) begin
      return TRAP_RET;
    end else if (branch_req) begin
      return BRANCH;
    end
    return NONE;
  endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Combinational priority select between the live request, the pending request and PC+4.
module pc_next_sel
  import cpu_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] epc,
  input  redirect_e   live_kind,
  input  logic [31:0] live_target,
  input  redirect_e   pend_kind,
  input  logic [31:0] pend_target,
  output logic [31:0] next_pc,
  output redirect_e   applied_kind,
  output logic        epc_we
);

  logic [31:0] sel_target;

  always_comb begin
    // Pending wins ties; the live request only overrides when strictly higher
    if (live_kind > pend_kind) begin
      applied_kind = live_kind;
      sel_target   = live_target;
    end else begin
      applied_kind = pend_kind;
      sel_target   = pend_target;
    end

    epc_we = 1'b0;
    unique case (applied_kind)
      TRAP: begin
        next_pc = TRAP_VEC;
        epc_we  = 1'b1;
      end
      TRAP_RET: next_pc = epc;
      BRANCH:   next_pc = sel_target;
      default:  next_pc = pc + PC_STEP;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: owns PC/EPC, applies redirects, holds redirects across
// BUSYWAIT stalls and pulses FLUSH after every applied redirect.
module pc_sequencer
  import cpu_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        BUSYWAIT,
  input  logic        BRANCH_TAKEN,
  input  logic [31:0] BRANCH_TARGET,
  input  logic        TRAP,
  input  logic        TRAP_RETURN,
  output logic [31:0] PC,
  output logic [31:0] EPC,
  output logic        PC_VALID,
  output logic        FLUSH
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] epc_q, epc_d;
  logic        valid_q, valid_d;
  logic        flush_q, flush_d;
  redirect_e   pend_kind_q, pend_kind_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;

  redirect_e   live_kind;
  logic [31:0] live_target;
  logic [31:0] sel_next_pc;
  redirect_e   sel_kind;
  logic        sel_epc_we;

  assign live_kind   = req_kind(TRAP, TRAP_RETURN, BRANCH_TAKEN);
  assign live_target = BRANCH_TARGET & ~32'h3;

  pc_next_sel u_next_sel (
    .pc           (pc_q),
    .epc          (epc_q),
    .live_kind    (live_kind),
    .live_target  (live_target),
    .pend_kind    (pend_kind_q),
    .pend_target  (pend_tgt_q),
    .next_pc      (sel_next_pc),
    .applied_kind (sel_kind),
    .epc_we       (sel_epc_we)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    epc_d       = epc_q;
    valid_d     = valid_q;
    flush_d     = 1'b0;
    pend_kind_d = pend_kind_q;
    pend_tgt_d  = pend_tgt_q;

    case (state_q)
      BOOT: begin
        if (!BUSYWAIT) begin
          pc_d    = RESET_PC + PC_STEP;
          valid_d = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (BUSYWAIT) begin
          // Later request in the same stall replaces the pending one on equal or higher priority
          if (live_kind != NONE && live_kind >= pend_kind_q) begin
            pend_kind_d = live_kind;
            pend_tgt_d  = live_target;
          end
        end else begin
          pc_d = sel_next_pc;
          if (sel_epc_we) begin
            epc_d = pc_q;
          end
          flush_d     = (sel_kind != NONE);
          pend_kind_d = NONE;
          pend_tgt_d  = '0;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= BOOT;
      pc_q        <= RESET_PC;
      epc_q       <= '0;
      valid_q     <= 1'b0;
      flush_q     <= 1'b0;
      pend_kind_q <= NONE;
      pend_tgt_q  <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      epc_q       <= epc_d;
      valid_q     <= valid_d;
      flush_q     <= flush_d;
      pend_kind_q <= pend_kind_d;
      pend_tgt_q  <= pend_tgt_d;
    end
  end

  assign PC       = pc_q;
  assign EPC      = epc_q;
  assign PC_VALID = valid_q;
  assign FLUSH    = flush_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vector table, reset/boot corner sequences and a
// randomized run checked against a behavioural model.
`timescale 1ns / 1ps
module tb_pc_sequencer;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        BUSYWAIT;
  logic        BRANCH_TAKEN;
  logic [31:0] BRANCH_TARGET;
  logic        TRAP;
  logic        TRAP_RETURN;
  logic [31:0] PC;
  logic [31:0] EPC;
  logic        PC_VALID;
  logic        FLUSH;

  int checks = 0;
  int errors = 0;

  pc_sequencer dut (
    .CLK           (CLK),
    .RESET_N       (RESET_N),
    .BUSYWAIT      (BUSYWAIT),
    .BRANCH_TAKEN  (BRANCH_TAKEN),
    .BRANCH_TARGET (BRANCH_TARGET),
    .TRAP          (TRAP),
    .TRAP_RETURN   (TRAP_RETURN),
    .PC            (PC),
    .EPC           (EPC),
    .PC_VALID      (PC_VALID),
    .FLUSH         (FLUSH)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        busy;
    logic        br;
    logic        trap;
    logic        tret;
    logic [31:0] tgt;
    logic [31:0] pc;
    logic [31:0] epc;
    logic        flush;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic busy, logic br, logic trap, logic tret, logic [31:0] tgt,
                              logic [31:0] pc, logic [31:0] epc, logic flush);
    vec_t v;
    v.busy = busy; v.br = br; v.trap = trap; v.tret = tret; v.tgt = tgt;
    v.pc = pc; v.epc = epc; v.flush = flush;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic busy, input logic br, input logic trap, input logic tret,
                       input logic [31:0] tgt);
    BUSYWAIT = busy; BRANCH_TAKEN = br; TRAP = trap; TRAP_RETURN = tret; BRANCH_TARGET = tgt;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Behavioural model: requests ranked trap=3, return=2, branch=1, none=0
  logic [31:0] m_pc, m_epc, m_pend_tgt;
  logic        m_valid, m_flush, m_run;
  int          m_pend;

  function automatic void model_reset();
    m_pc = 32'hFFFF_FFFC; m_epc = 0; m_valid = 0; m_flush = 0; m_run = 0;
    m_pend = 0; m_pend_tgt = 0;
  endfunction

  function automatic void model_edge();
    int          rank;
    int          win;
    logic [31:0] dest;
    rank = TRAP ? 3 : TRAP_RETURN ? 2 : BRANCH_TAKEN ? 1 : 0;
    m_flush = 0;
    if (!m_run) begin
      if (!BUSYWAIT) begin
        m_pc = 32'd0; m_valid = 1; m_run = 1;
      end
    end else if (BUSYWAIT) begin
      if (rank != 0 && rank >= m_pend) begin
        m_pend = rank; m_pend_tgt = {BRANCH_TARGET[31:2], 2'b00};
      end
    end else begin
      win = m_pend; dest = m_pend_tgt;
      if (rank > m_pend) begin
        win = rank; dest = {BRANCH_TARGET[31:2], 2'b00};
      end
      m_pend = 0;
      if (win == 3) begin
        m_epc = m_pc; m_pc = 32'h100;
      end else if (win == 2) begin
        m_pc = m_epc;
      end else if (win == 1) begin
        m_pc = dest;
      end else begin
        m_pc = m_pc + 32'd4;
      end
      m_flush = (win != 0);
    end
  endfunction

  initial begin
    RESET_N = 1'b0;
    drive(0, 0, 0, 0, 0);

    // Directed table, starting from the boot edge
    tbl.push_back(mk(0, 0, 0, 0, 0,            32'h0000_0000, 0,     0));
    tbl.push_back(mk(0, 0, 0, 0, 0,            32'h0000_0004, 0,     0));
    tbl.push_back(mk(0, 0, 0, 0, 0,            32'h0000_0008, 0,     0));
    tbl.push_back(mk(0, 0, 0, 0, 0,            32'h0000_000C, 0,     0));
    tbl.push_back(mk(0, 0, 0, 0, 0,            32'h0000_0010, 0,     0));
    tbl.push_back(mk(0, 1, 0, 0, 32'h203,      32'h0000_0200, 0,     1));
    tbl.push_back(mk(0, 0, 0, 0, 0,            32'h0000_0204, 0,     0));
    tbl.push_back(mk(0, 1, 0, 0, 32'h40,       32'h0000_0040, 0,     1));
    tbl.push_back(mk(1, 1, 0, 0, 32'h80,       32'h0000_0040, 0,     0));
    tbl.push_back(mk(1, 0, 0, 0, 0,            32'h0000_0040, 0,     0));
    tbl.push_back(mk(1, 0, 0, 0, 0,            32'h0000_0040, 0,     0));
    tbl.push_back(mk(0, 0, 0, 0, 0,            32'h0000_0080, 0,     1));
    tbl.push_back(mk(0, 1, 0, 0, 32'h40,       32'h0000_0040, 0,     1));
    tbl.push_back(mk(1, 1, 0, 0, 32'h80,       32'h0000_0040, 0,     0));
    tbl.push_back(mk(1, 0, 1, 0, 0,            32'h0000_0040, 0,     0));
    tbl.push_back(mk(0, 0, 0, 0, 0,            32'h0000_0100, 32'h40, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0,            32'h0000_0104, 32'h40, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0,            32'h0000_0040, 32'h40, 1));
    tbl.push_back(mk(1, 1, 0, 0, 32'h300,      32'h0000_0040, 32'h40, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0,            32'h0000_0100, 32'h40, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0,            32'h0000_0104, 32'h40, 0));
    tbl.push_back(mk(0, 1, 0, 0, 32'hFFFF_FFF8, 32'hFFFF_FFF8, 32'h40, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0,            32'hFFFF_FFFC, 32'h40, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0,            32'h0000_0000, 32'h40, 0));

    #12;
    chk("reset_pc", PC, 32'hFFFF_FFFC);
    chk("reset_epc", EPC, 32'h0);
    chk("reset_valid", {31'b0, PC_VALID}, 32'd0);
    chk("reset_flush", {31'b0, FLUSH}, 32'd0);
    RESET_N = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].busy, tbl[i].br, tbl[i].trap, tbl[i].tret, tbl[i].tgt);
      tick();
      chk($sformatf("vec%0d_pc", i), PC, tbl[i].pc);
      chk($sformatf("vec%0d_epc", i), EPC, tbl[i].epc);
      chk($sformatf("vec%0d_flush", i), {31'b0, FLUSH}, {31'b0, tbl[i].flush});
      chk($sformatf("vec%0d_valid", i), {31'b0, PC_VALID}, 32'd1);
    end

    // Reset while a branch is pending: nothing survives
    drive(1, 1, 0, 0, 32'h500);
    tick();
    drive(1, 0, 0, 0, 0);
    #2 RESET_N = 1'b0;
    #1;
    chk("midrst_pc", PC, 32'hFFFF_FFFC);
    chk("midrst_flush", {31'b0, FLUSH}, 32'd0);
    chk("midrst_valid", {31'b0, PC_VALID}, 32'd0);
    chk("midrst_epc", EPC, 32'h0);
    #2 RESET_N = 1'b1;
    // BUSYWAIT held in BOOT delays the first increment
    tick();
    chk("bootstall_pc", PC, 32'hFFFF_FFFC);
    chk("bootstall_valid", {31'b0, PC_VALID}, 32'd0);
    drive(0, 0, 0, 0, 0);
    tick();
    chk("reboot_pc", PC, 32'h0);
    chk("reboot_flush", {31'b0, FLUSH}, 32'd0);
    chk("reboot_valid", {31'b0, PC_VALID}, 32'd1);
    tick();
    chk("nopend_pc", PC, 32'h4);

    // Randomized run against the model
    #2 RESET_N = 1'b0;
    #2 RESET_N = 1'b1;
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      drive(($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 25),
            ($urandom_range(0, 99) < 8), ($urandom_range(0, 99) < 10), $urandom);
      tick();
      model_edge();
      chk("rnd_pc", PC, m_pc);
      chk("rnd_epc", EPC, m_epc);
      chk("rnd_valid", {31'b0, PC_VALID}, {31'b0, m_valid});
      chk("rnd_flush", {31'b0, FLUSH}, {31'b0, m_flush});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
